// File: rtl/z_seq_cla_adder.sv
// z_seq_cla_adder: multi-cycle adder, CHUNK bits per clock with in-chunk carry lookahead; Z_SEQ_ADDER_SUB_EN enables subtract
module z_seq_cla_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             grp_p,
  output logic             grp_g
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cy_q, cy_d, c_out_q, c_out_d, ovf_q, ovf_d, gp_q, gp_d, gg_q, gg_d;
  logic sub_eff;
  logic [CHUNK-1:0] ca, cb, p, g, s;
  logic [CHUNK:0] c;
  logic pch, gch;
`ifdef Z_SEQ_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff = 1'b0;
`endif
  always_comb begin
    ca = a_q[idx_q*CHUNK +: CHUNK];
    cb = b_q[idx_q*CHUNK +: CHUNK];
    p = ca ^ cb;
    g = ca & cb;
    c = '0;
    c[0] = cy_q;
    gch = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      gch = g[k] | (p[k] & gch);
    end
    s = p ^ c[CHUNK-1:0];
    pch = &p;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    cy_d = cy_q;
    sum_d = sum_q;
    c_out_d = c_out_q;
    ovf_d = ovf_q;
    gp_d = gp_q;
    gg_d = gg_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        idx_d = '0;
        a_d = a;
        b_d = sub_eff ? ~b : b;
        cy_d = sub_eff | c_in;
        gp_d = 1'b1;
        gg_d = 1'b0;
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s;
        cy_d = c[CHUNK];
        gp_d = gp_q & pch;
        gg_d = gch | (pch & gg_q);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NCHUNK - 1)) begin
          state_d = DONE;
          idx_d = '0;
          c_out_d = c[CHUNK];
          ovf_d = c[CHUNK-1] ^ c[CHUNK];
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cy_q <= 1'b0;
      sum_q <= '0;
      c_out_q <= 1'b0;
      ovf_q <= 1'b0;
      gp_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      cy_q <= cy_d;
      sum_q <= sum_d;
      c_out_q <= c_out_d;
      ovf_q <= ovf_d;
      gp_q <= gp_d;
      gg_q <= gg_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign c_out = c_out_q;
  assign ovf = ovf_q;
  assign grp_p = gp_q;
  assign grp_g = gg_q;
endmodule

// File: tb/tb_z_seq_cla_adder.sv
// tb_z_seq_cla_adder: directed vectors for z_seq_cla_adder (WIDTH=16, CHUNK=4)
module tb_z_seq_cla_adder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, c_out, ovf, grp_p, grp_g;
  logic [15:0] sum;
  int checks = 0, failures = 0;
  z_seq_cla_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .grp_p(grp_p), .grp_g(grp_g)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    chk("ready_before", in_ready, 1);
    a = ta;
    b = tb_;
    c_in = tc;
    sub = ts;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy"}, in_ready, 0);
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
  endtask
  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                     input logic ts, input logic [15:0] es, input logic ec, input logic eo,
                     input logic ep, input logic eg);
    start(ta, tb_, tc, ts);
    wait_done(tag);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, c_out, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_gp"}, grp_p, ep);
    chk({tag, "_gg"}, grp_g, eg);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_ovdrop"}, out_valid, 0);
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_sum", sum, 0);
    chk("rst_flags", {c_out, ovf, grp_p, grp_g, out_valid}, 0);
    chk("rst_ready", in_ready, 1);
    run("basic", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0, 0);
    run("ripple1", 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1, 0);
    run("ripple2", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 1);
    run("ovf_pos", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 0);
    run("ovf_neg", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 0, 1);
    start(16'h0101, 16'h0202, 0, 0);
    wait_done("bp");
    a = 16'hAAAA;
    b = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sum", sum, 16'h0303);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", in_ready, 1);
    step();
    chk("bp_nocapture", in_ready, 1);
    run("bp_next", 16'hAAAA, 16'h1111, 0, 0, 16'hBBBB, 0, 0, 0, 0);
    start(16'h1234, 16'h1111, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sum", sum, 0);
    chk("abort_flags", {c_out, ovf, grp_p, grp_g, out_valid}, 0);
    chk("abort_ready", in_ready, 1);
    run("after_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 0, 0);
`ifdef Z_SEQ_ADDER_SUB_EN
    run("sub", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0, 0);
`else
    run("sub", 16'h0005, 16'h0007, 0, 1, 16'h000C, 0, 0, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
